walk_service_fsm: RTL and testbench
===================================

// Module: walk_service_fsm
// PURPOSE
//  Traffic-light sequencer that consumes the latched pedestrian request from WalkReg (WalkReq).
//  Clears that request by pulsing WalkReg_Reset, closing the set/clear handshake with WalkReg.
//  Drives main-street and side-street R/Y/G lamps plus the Walk lamp.
//  Intervals are counted in Tick enables (1 Hz strobe from the clock divider).
// PARAMETERS
//  T_BASE  6  main-green base interval, in ticks (>=1)
//  T_EXT   3  main-green extension when Sensor set; also the side-green interval (>=1)
//  T_YEL   2  yellow interval for both streets (>=1)
//  T_WALK  3  all-red walk interval (>=1)
//  TW      4  timer width; must hold max(T_*)-1
// PORTS
//  clk            in   1  system clock
//  Reset          in   1  synchronous, active-high reset
//  Tick           in   1  one-cycle interval-count enable
//  WalkReq        in   1  latched pedestrian request from WalkReg
//  Sensor         in   1  side-street vehicle sensor, already synchronised
//  Main_RYG       out  3  main lamps {R,Y,G}, one-hot
//  Side_RYG       out  3  side lamps {R,Y,G}, one-hot
//  Walk           out  1  pedestrian Walk lamp
//  WalkReg_Reset  out  1  one-cycle clear pulse to WalkReg
// BEHAVIOUR
//  Single clock domain, clk. Reset is synchronous and active-high. All outputs are registered.
//  Reset: state=MAIN_G, timer=T_BASE-1, ext_done=0, Main_RYG=001, Side_RYG=100, Walk=0, WalkReg_Reset=0.
//   Reset has priority over every other event, including mid-interval and mid-WALK.
//  Timer: loaded with N-1 on the cycle a state is entered; decrements on Tick.
//   Expiry = (timer==0 && Tick); the state changes on that clock edge.
//   Each state therefore lasts exactly N ticks. Tick=0 freezes everything.
//  States and transitions, all taken on expiry:
//   MAIN_G  (Main=001, Side=100)
//    -> if Sensor && !ext_done: reload T_EXT-1, set ext_done, stay in MAIN_G
//    -> else MAIN_Y
//   MAIN_Y  (Main=010, Side=100)
//    -> WALK if WalkReq==1 at expiry, else SIDE_G
//   WALK    (Main=100, Side=100, Walk=1) -> SIDE_G
//   SIDE_G  (Main=100, Side=001) -> SIDE_Y
//   SIDE_Y  (Main=100, Side=010) -> MAIN_G; ext_done cleared on this transition
//  At most one extension per MAIN_G visit. Sensor is sampled only at expiry of the base interval.
//  WalkReg_Reset=1 for exactly the first cycle of WALK, 0 at all other times.
//  WalkReq rising while in WALK is not served in the current visit.
//   It stays latched in WalkReg and is served at the next MAIN_Y expiry.
//  WalkReq arriving during SIDE_G, SIDE_Y or MAIN_G is held by WalkReg.
//   It is served at the next MAIN_Y expiry.
//  Never two greens at once. Exactly one lamp per street is lit every cycle after reset.
// STRUCTURE
//  tlc_pkg: state enum {MAIN_G,MAIN_Y,WALK,SIDE_G,SIDE_Y}.
//   Lamp constants RYG_R=3'b100, RYG_Y=3'b010, RYG_G=3'b001.
//  One sub-module, interval_timer (TW-bit): load/value/tick inputs, expire output.
//  FSM, lamp decode and WalkReg_Reset pulse live in walk_service_fsm.
// TESTING  (defaults, Tick tied 1 unless stated; cycles counted from Reset deassert)
//  1 No Sensor, no WalkReq -> MAIN_G 6 cyc, MAIN_Y 2, SIDE_G 3, SIDE_Y 2; period 13 cyc, repeats.
//  2 Sensor=1 throughout -> MAIN_G 9 cyc (one extension only), then MAIN_Y 2; no further extension.
//  3 WalkReq pulse at cyc 2 (held by WalkReg model) -> WALK at cyc 8 for 3 cyc.
//    Walk=1, both lamps 100, WalkReg_Reset=1 at cyc 8 only; then SIDE_G.
//  4 Tick every 4th cycle -> every interval stretched 4x (MAIN_G=24 cyc); lamps stable between ticks.
//  5 Reset asserted 1 cyc mid-WALK -> next edge MAIN_G, Main=001, Walk=0, WalkReg_Reset=0.
//  6 WalkReq set during WALK -> no second pulse this visit; served at the following MAIN_Y expiry.
//  All tests: assert one-hot lamps, no dual green, WalkReg_Reset width exactly 1 cycle.

Source files
------------

// File: rtl/tlc_pkg.sv
// ----------------------------------------------------------------------------
// tlc_pkg
// Shared types and constants for the walk-service traffic-light sequencer.
//   tlc_state_e : sequencer states MAIN_G, MAIN_Y, WALK, SIDE_G, SIDE_Y
//   RYG_*       : one-hot lamp codes, bit order {R,Y,G}
//   lamp_set_t  : lamp outputs produced for a given state
//   lampDecode  : maps a state to its lamp set
// ----------------------------------------------------------------------------
package tlc_pkg;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        WALK   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4
    } tlc_state_e;

    localparam logic [2:0] RYG_R = 3'b100;
    localparam logic [2:0] RYG_Y = 3'b010;
    localparam logic [2:0] RYG_G = 3'b001;

    typedef struct packed {
        logic [2:0] mainRyg;
        logic [2:0] sideRyg;
        logic       walk;
    } lamp_set_t;

    // Every state lights exactly one lamp per street; any cross street that is
    // not green or yellow is held red, so two greens can never coexist.
    function automatic lamp_set_t lampDecode(input tlc_state_e s);
        lamp_set_t l;
        l.mainRyg = RYG_R;
        l.sideRyg = RYG_R;
        l.walk    = 1'b0;
        case (s)
            MAIN_G: l.mainRyg = RYG_G;
            MAIN_Y: l.mainRyg = RYG_Y;
            WALK:   l.walk    = 1'b1;
            SIDE_G: l.sideRyg = RYG_G;
            SIDE_Y: l.sideRyg = RYG_Y;
            default: l.mainRyg = RYG_G;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/walk_service_fsm_interval_timer.sv
// ----------------------------------------------------------------------------
// interval_timer
// Down-counter that measures a state interval in Tick enables.
//   clk        : system clock
//   Reset      : synchronous active-high reset, loads RESET_VALUE
//   load_i     : load value_i this cycle (takes priority over counting)
//   value_i    : interval length minus one
//   tick_i     : count enable
//   expire_o   : combinational, high when the count is zero and tick_i is high
// ----------------------------------------------------------------------------
module interval_timer #(
    parameter int             TW          = 4,
    parameter logic [TW-1:0]  RESET_VALUE = '0
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          load_i,
    input  logic [TW-1:0] value_i,
    input  logic          tick_i,
    output logic          expire_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // A load always wins: the owner reloads on the very tick that expires, so
    // the count never has to wrap below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    // Count register; reset preloads the first interval so no extra cycle is
    // spent loading after reset is released.
    always_ff @(posedge clk) begin
        if (Reset) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = tick_i && (count_q == '0);

endmodule

// File: rtl/walk_service_fsm.sv
// ----------------------------------------------------------------------------
// walk_service_fsm
// Traffic-light sequencer serving a latched pedestrian request.
//   clk           : system clock
//   Reset         : synchronous active-high reset
//   Tick          : one-cycle interval-count enable (1 Hz strobe)
//   WalkReq       : latched pedestrian request from WalkReg
//   Sensor        : synchronised side-street vehicle sensor
//   Main_RYG      : main-street lamps {R,Y,G}, one-hot, registered
//   Side_RYG      : side-street lamps {R,Y,G}, one-hot, registered
//   Walk          : pedestrian Walk lamp, registered
//   WalkReg_Reset : one-cycle clear pulse to WalkReg on entry to WALK
// ----------------------------------------------------------------------------
module walk_service_fsm
    import tlc_pkg::*;
#(
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2,
    parameter int T_WALK = 3,
    parameter int TW     = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       WalkReq,
    input  logic       Sensor,
    output logic [2:0] Main_RYG,
    output logic [2:0] Side_RYG,
    output logic       Walk,
    output logic       WalkReg_Reset
);

    tlc_state_e    state_q;
    tlc_state_e    state_d;
    logic          extDone_q;
    logic          extDone_d;
    lamp_set_t     lamps_q;
    lamp_set_t     lamps_d;
    logic          walkPulse_q;
    logic          walkPulse_d;

    logic          timerLoad;
    logic [TW-1:0] timerValue;
    logic          timerExpire;

    interval_timer #(
        .TW          (TW),
        .RESET_VALUE (TW'(T_BASE - 1))
    ) u_timer (
        .clk      (clk),
        .Reset    (Reset),
        .load_i   (timerLoad),
        .value_i  (timerValue),
        .tick_i   (Tick),
        .expire_o (timerExpire)
    );

    // Next-state logic. Nothing moves except on timer expiry; every expiry
    // reloads the timer with the length of the interval being started, which
    // includes the single main-green extension that keeps the state unchanged.
    always_comb begin
        state_d    = state_q;
        extDone_d  = extDone_q;
        timerLoad  = 1'b0;
        timerValue = '0;
        if (timerExpire) begin
            timerLoad = 1'b1;
            case (state_q)
                MAIN_G: begin
                    if (Sensor && !extDone_q) begin
                        extDone_d  = 1'b1;
                        timerValue = TW'(T_EXT - 1);
                    end else begin
                        state_d    = MAIN_Y;
                        timerValue = TW'(T_YEL - 1);
                    end
                end
                MAIN_Y: begin
                    if (WalkReq) begin
                        state_d    = WALK;
                        timerValue = TW'(T_WALK - 1);
                    end else begin
                        state_d    = SIDE_G;
                        timerValue = TW'(T_EXT - 1);
                    end
                end
                WALK: begin
                    state_d    = SIDE_G;
                    timerValue = TW'(T_EXT - 1);
                end
                SIDE_G: begin
                    state_d    = SIDE_Y;
                    timerValue = TW'(T_YEL - 1);
                end
                SIDE_Y: begin
                    state_d    = MAIN_G;
                    extDone_d  = 1'b0;
                    timerValue = TW'(T_BASE - 1);
                end
                default: begin
                    state_d    = MAIN_G;
                    extDone_d  = 1'b0;
                    timerValue = TW'(T_BASE - 1);
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered lamps change
    // on the same edge as the state, and the clear pulse fires only on the
    // edge that enters WALK.
    always_comb begin
        lamps_d     = lampDecode(state_d);
        walkPulse_d = (state_d == WALK) && (state_q != WALK);
    end

    // State and output registers; reset overrides any interval in progress.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= MAIN_G;
            extDone_q   <= 1'b0;
            lamps_q     <= '{mainRyg: RYG_G, sideRyg: RYG_R, walk: 1'b0};
            walkPulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            extDone_q   <= extDone_d;
            lamps_q     <= lamps_d;
            walkPulse_q <= walkPulse_d;
        end
    end

    assign Main_RYG      = lamps_q.mainRyg;
    assign Side_RYG      = lamps_q.sideRyg;
    assign Walk          = lamps_q.walk;
    assign WalkReg_Reset = walkPulse_q;

endmodule

// File: tb/tb_walk_service_fsm.sv
// ----------------------------------------------------------------------------
// tb_walk_service_fsm
// Scoreboard bench for walk_service_fsm. A driver issues one cycle of stimulus
// at each falling edge, advances a phase/tick-count reference model and queues
// the lamp set expected after the next rising edge. A monitor pops and compares
// shortly after every rising edge.
// ----------------------------------------------------------------------------
module tb_walk_service_fsm;

    localparam int T_BASE = 6;
    localparam int T_EXT  = 3;
    localparam int T_YEL  = 2;
    localparam int T_WALK = 3;
    localparam int TW     = 4;

    logic       clk     = 1'b0;
    logic       Reset   = 1'b1;
    logic       Tick    = 1'b0;
    logic       WalkReq = 1'b0;
    logic       Sensor  = 1'b0;
    logic [2:0] Main_RYG;
    logic [2:0] Side_RYG;
    logic       Walk;
    logic       WalkReg_Reset;

    walk_service_fsm #(
        .T_BASE (T_BASE),
        .T_EXT  (T_EXT),
        .T_YEL  (T_YEL),
        .T_WALK (T_WALK),
        .TW     (TW)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .Tick          (Tick),
        .WalkReq       (WalkReq),
        .Sensor        (Sensor),
        .Main_RYG      (Main_RYG),
        .Side_RYG      (Side_RYG),
        .Walk          (Walk),
        .WalkReg_Reset (WalkReg_Reset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic       p;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    // Phase order 0..4 = main green, main yellow, walk, side green, side yellow.
    int         durTab[5]  = '{T_BASE, T_YEL, T_WALK, T_EXT, T_YEL};
    logic [2:0] mainTab[5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    logic [2:0] sideTab[5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010};

    int phase     = 0;
    int ticksUsed = 0;
    int curDur    = T_BASE;
    bit extended  = 1'b0;
    bit walkLatch = 1'b0;
    bit prevPulse = 1'b0;

    // One clock of stimulus plus the reference model's view of that edge.
    // The bench also models WalkReg: a request sets it, the predicted clear
    // pulse empties it unless a new request arrives at the same moment.
    task automatic applyStimulus(input bit r, input bit t, input bit s, input bit req);
        int   oldPhase;
        bit   pulse;
        exp_t e;
        @(negedge clk);
        walkLatch = (walkLatch && !prevPulse) || req;
        Reset     = r;
        Tick      = t;
        Sensor    = s;
        WalkReq   = walkLatch;
        oldPhase  = phase;
        if (r) begin
            phase     = 0;
            ticksUsed = 0;
            curDur    = T_BASE;
            extended  = 1'b0;
        end else if (t) begin
            ticksUsed++;
            if (ticksUsed == curDur) begin
                ticksUsed = 0;
                if (phase == 0 && s && !extended) begin
                    extended = 1'b1;
                    curDur   = T_EXT;
                end else begin
                    if (phase == 0)      phase = 1;
                    else if (phase == 1) phase = walkLatch ? 2 : 3;
                    else if (phase == 2) phase = 3;
                    else if (phase == 3) phase = 4;
                    else begin
                        phase    = 0;
                        extended = 1'b0;
                    end
                    curDur = durTab[phase];
                end
            end
        end
        pulse = !r && (phase == 2) && (oldPhase != 2);
        e.m = mainTab[phase];
        e.s = sideTab[phase];
        e.w = (phase == 2);
        e.p = pulse;
        expQ.push_back(e);
        prevPulse = pulse;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
        end
    endtask

    // Monitor: the DUT presents registered outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("mainLamps", Main_RYG, e.m);
                checkOutput("sideLamps", Side_RYG, e.s);
                checkOutput("walkLamp", {2'b00, Walk}, {2'b00, e.w});
                checkOutput("walkRegReset", {2'b00, WalkReg_Reset}, {2'b00, e.p});
                checkOutput("mainOneHot", {2'b00, $onehot(Main_RYG)}, 3'b001);
                checkOutput("sideOneHot", {2'b00, $onehot(Side_RYG)}, 3'b001);
                checkOutput("dualGreen", {2'b00, Main_RYG[0] & Side_RYG[0]}, 3'b000);
            end
        end
    end

    // Drive the generator until the model enters the walk phase, bounded.
    task automatic reachWalk();
        applyStimulus(0, 1, 0, 1);
        for (int k = 0; k < 200 && phase != 2; k++) applyStimulus(0, 1, 0, 0);
        checks++;
        if (phase != 2) begin
            errors++;
            $display("[TB] FAIL reachWalk: walk phase not reached within bound");
        end
    endtask

    initial begin
        bit r;
        bit t;
        bit s;
        bit q;

        // Reset state, then a plain cycle with no sensor and no requests.
        repeat (3) applyStimulus(1, 1, 0, 0);
        repeat (40) applyStimulus(0, 1, 0, 0);

        // Sensor held high: exactly one extension per main-green visit.
        applyStimulus(1, 1, 0, 0);
        repeat (40) applyStimulus(0, 1, 1, 0);

        // Single request pulse early in main green.
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, i == 2);

        // Tick every fourth cycle stretches every interval.
        applyStimulus(1, 1, 0, 0);
        for (int i = 0; i < 120; i++) applyStimulus(0, (i % 4) == 3, 0, 0);

        // Reset in the middle of a walk interval.
        applyStimulus(1, 1, 0, 0);
        reachWalk();
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        repeat (20) applyStimulus(0, 1, 0, 0);

        // Request raised during walk is held and served on the next lap.
        applyStimulus(1, 1, 0, 0);
        reachWalk();
        applyStimulus(0, 1, 0, 1);
        repeat (40) applyStimulus(0, 1, 0, 0);

        // Randomised traffic, sensor, tick and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            t = ($urandom_range(0, 2) != 0);
            s = ($urandom_range(0, 3) == 0);
            q = ($urandom_range(0, 14) == 0);
            applyStimulus(r, t, s, q);
        end

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
